// File: rtl/parity3_pkg.sv
// Shared definitions for the 3-bit parity frame receiver.
package parity3_pkg;

  localparam int FRAME_DATA_BITS = 3;
  localparam int ERR_COUNT_W     = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Returns 1 when data plus parity bit do not match the selected parity sense.
  function automatic logic parity_fail(input logic [FRAME_DATA_BITS-1:0] data,
                                       input logic                       par,
                                       input logic                       odd);
    return (^data) ^ par ^ odd;
  endfunction

endpackage

// File: rtl/parity3_frame_rx_bit_timer.sv
// Mid-bit sample strobe generator. A restart with half=1 places the first
// tick half a bit later; after that a tick comes every CLKS_PER_BIT cycles.
module bit_timer
  import parity3_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic restart,
  input  logic half,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  // Next countdown value: reload on restart or on expiry, otherwise decrement.
  always_comb begin
    w_cnt_next = r_cnt;
    if (restart) begin
      w_cnt_next = half ? HALF_LOAD : FULL_LOAD;
    end else if (r_cnt == {CNT_W{1'b0}}) begin
      w_cnt_next = FULL_LOAD;
    end else begin
      w_cnt_next = r_cnt - CNT_W'(1);
    end
  end

  // Countdown register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign tick = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/parity3_frame_rx.sv
// Serial receiver for start + 3 data bits + parity + stop frames, with
// parity/framing checks and a saturating error counter.
module parity3_frame_rx
  import parity3_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD_PARITY   = 0
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       rx,
  output logic [FRAME_DATA_BITS-1:0] data_out,
  output logic                       data_valid,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       busy,
  output logic [ERR_COUNT_W-1:0]     err_count
);

  localparam int   BIT_CNT_W = $clog2(FRAME_DATA_BITS);
  localparam logic ODD_BIT   = (ODD_PARITY != 0);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(FRAME_DATA_BITS - 1);

  rx_state_t r_state;
  rx_state_t w_state_next;

  logic                       w_tick;
  logic                       w_restart;
  logic                       w_half;
  logic                       w_sample_data;
  logic                       w_sample_par;
  logic                       w_sample_stop;

  logic [BIT_CNT_W-1:0]       r_bit_cnt;
  logic [FRAME_DATA_BITS-1:0] r_shift;
  logic                       r_par;
  logic                       r_pend_valid;
  logic                       r_pend_perr;
  logic                       r_pend_ferr;
  logic [FRAME_DATA_BITS-1:0] r_data_out;
  logic                       r_data_valid;
  logic                       r_parity_err;
  logic                       r_frame_err;
  logic                       r_busy;
  logic [ERR_COUNT_W-1:0]     r_err_count;

  // The only restart is the start-bit detect, which always wants a half bit.
  assign w_half = (r_state == IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .nrst   (nrst),
    .restart(w_restart),
    .half   (w_half),
    .tick   (w_tick)
  );

  // Next-state and sample-strobe decode; only timer ticks move past START.
  always_comb begin
    w_state_next  = r_state;
    w_restart     = 1'b0;
    w_sample_data = 1'b0;
    w_sample_par  = 1'b0;
    w_sample_stop = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rx) begin
          w_state_next = START;
          w_restart    = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_next = rx ? IDLE : DATA;
        end else begin
          w_state_next = START;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_sample_data = 1'b1;
          w_state_next  = (r_bit_cnt == LAST_DATA) ? PARITY : DATA;
        end else begin
          w_state_next = DATA;
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_sample_par = 1'b1;
          w_state_next = STOP;
        end else begin
          w_state_next = PARITY;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_sample_stop = 1'b1;
          w_state_next  = IDLE;
        end else begin
          w_state_next = STOP;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register plus busy, registered from the next state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != IDLE);
    end
  end

  // Shift register, bit counter and captured parity bit.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_bit_cnt <= {BIT_CNT_W{1'b0}};
      r_shift   <= {FRAME_DATA_BITS{1'b0}};
      r_par     <= 1'b0;
    end else if (w_restart) begin
      r_bit_cnt <= {BIT_CNT_W{1'b0}};
      r_shift   <= {FRAME_DATA_BITS{1'b0}};
      r_par     <= 1'b0;
    end else if (w_sample_data) begin
      r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
      r_shift   <= {r_shift[FRAME_DATA_BITS-2:0], rx};
    end else if (w_sample_par) begin
      r_par <= rx;
    end else begin
      r_bit_cnt <= r_bit_cnt;
    end
  end

  // Frame completion: latch data and checks on the stop sample edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_data_out   <= {FRAME_DATA_BITS{1'b0}};
      r_pend_valid <= 1'b0;
      r_pend_perr  <= 1'b0;
      r_pend_ferr  <= 1'b0;
    end else if (w_sample_stop) begin
      r_data_out   <= r_shift;
      r_pend_valid <= 1'b1;
      r_pend_perr  <= parity_fail(r_shift, r_par, ODD_BIT);
      r_pend_ferr  <= ~rx;
    end else begin
      r_pend_valid <= 1'b0;
      r_pend_perr  <= 1'b0;
      r_pend_ferr  <= 1'b0;
    end
  end

  // One-cycle result pulses and the saturating error counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_count  <= {ERR_COUNT_W{1'b0}};
    end else begin
      r_data_valid <= r_pend_valid;
      r_parity_err <= r_pend_valid & r_pend_perr;
      r_frame_err  <= r_pend_valid & r_pend_ferr;
      if (r_pend_valid && (r_pend_perr || r_pend_ferr) &&
          (r_err_count != {ERR_COUNT_W{1'b1}})) begin
        r_err_count <= r_err_count + ERR_COUNT_W'(1);
      end else begin
        r_err_count <= r_err_count;
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;
  assign err_count  = r_err_count;

endmodule
